// File: rtl/ifetch.sv
// ifetch: instruction fetch stage. Owns the fetch PC and fetches words over
// a req/ack handshake. A single buffered word is presented to IF/ID.
// A request killed by a redirect is drained before the new target is requested.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifdwrite,
    input  logic        ifflush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] next_instr,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] req_addr;
    logic [31:0] buf_instr;
    logic [31:0] buf_addr;
    logic [31:0] tgt;
    logic [31:0] seq_pc;
    logic        consume;

    // Word-aligned redirect target and the sequential successor of the held word
    assign tgt     = {redirect_pc[31:2], 2'b00};
    assign seq_pc  = buf_addr + 32'd4;
    assign consume = (state == HOLD) && (ifflush || !ifdwrite);

    // Fetch FSM: redirect has priority over ack and consume in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc_q      <= RESET_PC;
            req_addr  <= RESET_PC;
            buf_instr <= 32'h0;
            buf_addr  <= 32'h0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        pc_q <= tgt;
                        // Ack in the same cycle retires the old request, so the
                        // new target can be requested right away; otherwise drain.
                        if (imem_ack) req_addr <= tgt;
                        else          state    <= DRAIN;
                    end else if (imem_ack) begin
                        buf_instr <= imem_rdata;
                        buf_addr  <= req_addr;
                        state     <= HOLD;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        req_addr <= redirect ? tgt : pc_q;
                        pc_q     <= redirect ? tgt : pc_q;
                        state    <= FETCH;
                    end else if (redirect) begin
                        pc_q <= tgt;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_q     <= tgt;
                        req_addr <= tgt;
                        state    <= FETCH;
                    end else if (consume) begin
                        pc_q     <= seq_pc;
                        req_addr <= seq_pc;
                        state    <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Request is withdrawn combinationally while reset is asserted
    assign imem_req   = (state != HOLD) && !rst;
    assign imem_addr  = req_addr;
    // IF/ID only ever sees the buffered word, so a stalled consumer sees no change
    assign instr      = (state == HOLD) ? buf_instr : 32'h0;
    assign next_instr = (state == HOLD) ? seq_pc    : 32'h0;
    assign pc         = pc_q;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: random and directed stimulus for ifetch, checked against a
// transaction-level model (outstanding request, held word, next fetch PC).
module tb_ifetch;

    localparam logic [31:0] RPC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifdwrite = 1'b0;
    logic        ifflush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] next_instr;
    logic [31:0] pc;

    ifetch #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .ifdwrite(ifdwrite), .ifflush(ifflush),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .next_instr(next_instr), .pc(pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory: per request, a random wait count in [w_lo,w_hi] and random data
    int          w_lo = 0, w_hi = 0;
    bit          busy = 0;
    int          cnt, wt;
    logic [31:0] rdat;
    logic [31:0] force_data = 32'h0;
    bit          use_force = 0;

    // Reference model in transaction terms
    bit          m_out  = 0;   // a request is on the bus
    bit          m_live = 0;   // its data will be kept
    logic [31:0] m_oaddr = 0;
    logic [31:0] m_pc = 0;
    bit          m_held = 0;
    logic [31:0] m_word = 0, m_waddr = 0;

    task automatic issue(input logic [31:0] a);
        m_out = 1; m_live = 1; m_oaddr = a; m_pc = a;
    endtask

    task automatic step(input bit r, input bit dw, input bit fl, input bit rd, input logic [31:0] rpc);
        bit          ack;
        logic [31:0] t;
        @(negedge clk);
        rst = r; ifdwrite = dw; ifflush = fl; redirect = rd; redirect_pc = rpc;
        #1;
        chk("imem_req", {31'h0, imem_req}, {31'h0, m_out && !r});
        if (m_out && !r) chk("imem_addr", imem_addr, m_oaddr);
        if (!r) begin
            chk("instr", instr, m_held ? m_word : 32'h0);
            chk("next_instr", next_instr, m_held ? m_waddr + 32'd4 : 32'h0);
            chk("pc", pc, m_pc);
        end
        if (r) busy = 0;
        else if (imem_req && !busy) begin
            busy = 1; cnt = 0; wt = $urandom_range(w_hi, w_lo);
            rdat = use_force ? force_data : $urandom;
        end
        ack = !r && busy && (cnt == wt);
        imem_ack = ack;
        imem_rdata = ack ? rdat : 32'hDEAD_BEEF;
        t = rpc & ~32'h3;
        if (r) begin
            m_held = 0; issue(RPC);
        end else if (m_held) begin
            if (rd)            begin m_held = 0; issue(t); end
            else if (fl || !dw) begin m_held = 0; issue(m_waddr + 32'd4); end
        end else if (ack) begin
            if (m_live && !rd) begin
                m_held = 1; m_word = rdat; m_waddr = m_oaddr; m_out = 0;
            end else issue(rd ? t : m_pc);
        end else if (rd) begin
            m_pc = t; m_live = 0;
        end
        @(posedge clk);
        if (busy) begin
            if (ack) busy = 0;
            else cnt++;
        end
    endtask

    task automatic until_held(input int lim);
        for (int i = 0; i < lim && !m_held; i++) step(0, 1, 0, 0, 0);
        chk("held_timeout", {31'h0, m_held}, 32'h1);
    endtask

    initial begin
        // Reset, zero-wait streaming from 0x40
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        #1 chk("rst_pc", pc, RPC);
        chk("rst_instr", instr, 32'h0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
        #1 chk("stream_addr", imem_addr, 32'h4C);

        // Hold a fixed word for 5 cycles, then release
        use_force = 1; force_data = 32'h8C22_0004;
        until_held(8);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        #1 chk("hold_instr", instr, 32'h8C22_0004);
        chk("hold_req", {31'h0, imem_req}, 32'h0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        use_force = 0;

        // 3 wait states, redirect to 0x100 in the second wait cycle
        w_lo = 3; w_hi = 3;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h100);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        #1 chk("drain_addr", imem_addr, 32'h100);
        until_held(8);

        // Redirect with flush while holding
        w_lo = 0; w_hi = 0;
        step(0, 1, 1, 1, 32'h203);
        #1 chk("hold_redir", imem_addr, 32'h200);

        // Wrap at the top of the address space
        step(0, 0, 0, 1, 32'hFFFF_FFFC);
        until_held(8);
        #1 chk("wrap_next", next_instr, 32'h0);
        step(0, 0, 0, 0, 0);
        #1 chk("wrap_addr", imem_addr, 32'h0);

        // Reset while draining
        w_lo = 3; w_hi = 3;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h300);
        step(1, 0, 0, 0, 0);
        #1 chk("drain_rst_pc", pc, RPC);
        step(0, 0, 0, 0, 0);

        // Random traffic
        w_lo = 0; w_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tg;
            tg = ($urandom_range(15, 0) == 0) ? 32'hFFFF_FFFC : $urandom;
            step($urandom_range(63, 0) == 0, $urandom_range(1, 0) == 1,
                 $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0, tg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage: it owns the program counter, fetches instruction words from instruction memory over a req/ack handshake, and presents `instr` and `next_instr` (PC+4) to the IF/ID pipeline register. It honours the IF/ID hold (`ifdwrite`) and flush (`ifflush`) controls and takes PC redirects from branch/jump resolution. When no fetched word is held, it presents a NOP bubble (all zeros).

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk`  in  1: single clock, all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ifdwrite`  in  1: 1 means IF/ID is holding and does not consume at this edge.
- `ifflush`  in  1: 1 means IF/ID is flushing; the held word is discarded and counts as consumed.
- `redirect`  in  1: load a new PC at this edge (taken branch or jump).
- `redirect_pc`  in  32: target PC; bits [1:0] are ignored and forced to 0.
- `imem_req`  out  1: fetch request; held high until ack.
- `imem_addr`  out  32: word address of the outstanding request; stable while `imem_req`=1.
- `imem_ack`  in  1: one-cycle completion pulse; may arrive in the first cycle of `imem_req`.
- `imem_rdata`  in  32: instruction word, valid only when `imem_ack`=1.
- `instr`  out  32: held instruction, or 32'h0 when none is held.
- `next_instr`  out  32: address of the held instruction + 4, or 32'h0 when none is held.
- `pc`  out  32: the architectural fetch PC, i.e. the address of the next word to request.

## Operation
- Registers:
  - `pc`.
  - `req_addr`, which drives `imem_addr`.
  - a 32-bit instruction buffer and a 32-bit buffer-address register.
  - state.
- States:
  - FETCH: request outstanding. `imem_req`=1 and `imem_addr`=`req_addr`.
  - DRAIN: a request is outstanding but was killed by a redirect. `imem_req`=1 and the returning data is dropped.
  - HOLD: the buffer is valid. `imem_req`=0 and the outputs show the buffer.
- Consume condition: `consume` = HOLD && (`ifflush` || !`ifdwrite`).
- Transitions, with `redirect` taking highest priority:
  - FETCH, `redirect`=1, `imem_ack`=1: drop the data, `pc` and `req_addr` get `redirect_pc`, stay in FETCH.
  - FETCH, `redirect`=1, `imem_ack`=0: `pc` gets `redirect_pc`, `req_addr` is unchanged, go to DRAIN.
  - FETCH, `redirect`=0, `imem_ack`=1: the buffer takes `imem_rdata` and `req_addr`, go to HOLD.
  - DRAIN, `imem_ack`=1: `req_addr` gets `pc` (including any `redirect_pc` arriving in the same cycle), go to FETCH.
  - DRAIN, `imem_ack`=0 and `redirect`=1: `pc` is updated, stay in DRAIN.
  - HOLD, `redirect`=1: the buffer is invalidated, `pc` and `req_addr` get `redirect_pc`, go to FETCH. This applies whether or not a consume happens.
  - HOLD, `consume` with no redirect: `pc` and `req_addr` get the buffer address + 4, go to FETCH.
  - HOLD, no consume: hold all registers.
- `pc` tracks the address of the next request; in HOLD it equals the buffer address.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Output muxing: `instr` and `next_instr` show the buffer only in HOLD, and 0 otherwise. A stalled consumer therefore never sees a changed word.

## Timing
- Reset values, in and after any rst=1 cycle:
  - state FETCH, `pc` and `req_addr` = `RESET_PC`, buffer invalid.
  - `instr`=0, `next_instr`=0.
  - `imem_req` is forced to 0 while `rst`=1.
- Reset asserted mid-request: the outstanding request is abandoned. Memory must tolerate the request being withdrawn.
- Zero-wait memory, where ack arrives in the first req cycle:
  - req in cycle N, word visible on `instr` in N+1, consumed at the end of N+1, next req in N+2.
  - Throughput is 1 instruction per 2 cycles.
- A word is visible to IF/ID from the cycle after its ack until the edge on which it is consumed.
- Redirect latency: redirect at edge E gives a request to `redirect_pc` in cycle E+1, or in the cycle after the drain ack.
- Simultaneous `ifflush`=1 and `ifdwrite`=1: flush wins and the word is consumed.
- `imem_ack` while in HOLD is a protocol violation and is ignored.

## Test plan
- Reset with `RESET_PC`=32'h0000_0040, zero-wait memory, `ifdwrite`=0:
  - requests go to 0x40, 0x44, 0x48 on alternate cycles.
  - `next_instr` = 0x44, 0x48, 0x4C.
  - `instr` = 0 in the cycles between words.
- Word 0x8C220004 held in HOLD with `ifdwrite`=1 for 5 cycles:
  - `instr` stays 0x8C220004 and `imem_req` stays 0 throughout.
  - after release, the next request goes to buffer address + 4.
- 3-wait-state memory with `redirect`=1 to 0x100 in the second wait cycle:
  - `imem_addr` stays at the old address until ack, then the old data is dropped.
  - the next request is to 0x100 and `instr` never shows the dropped word.
- In HOLD, `redirect` to 0x200 together with `ifflush`=1:
  - the buffer is dropped and the next request is to 0x200.
- In HOLD at 32'hFFFF_FFFC, consume: the next request is to 0x0 and `next_instr` was 0x0.
- `rst` asserted while in DRAIN:
  - next cycle state is FETCH, `pc` = `RESET_PC`, and `imem_req` goes low during the reset cycle.
